// File: rtl/flip_flop_d_latch.sv
`default_nettype none
// ============================================================================
// Module   : d_latch
// Brief    : Level-sensitive D latch; q follows d while en is high and holds
//            its value while en is low.
// Revision : 1.0
// ============================================================================
module d_latch (
    input  logic en,
    input  logic d,
    output logic q
);

    always_latch begin
        if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/flip_flop.sv
`default_nettype none
// ============================================================================
// Module   : flip_flop
// Brief    : Positive-edge D flip-flop of WIDTH independent bits, built from
//            master-slave latch pairs; synchronous active-low reset.
// Revision : 1.0
// ============================================================================
module flip_flop #(
    parameter int WIDTH = 1
) (
    input  logic             clkPE,
    input  logic             rstN,
    input  logic [WIDTH-1:0] inp,
    output logic [WIDTH-1:0] outp
);

    logic             w_master_en;
    logic [WIDTH-1:0] w_master_d;
    logic [WIDTH-1:0] w_master_q;

    // Master tracks the (reset-gated) input while the clock is low and closes
    // on the rising edge; the slave then exposes what the master held.
    assign w_master_en = ~clkPE;
    assign w_master_d  = inp & {WIDTH{rstN}};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_latch u_master (
            .en (w_master_en),
            .d  (w_master_d[i]),
            .q  (w_master_q[i])
        );

        d_latch u_slave (
            .en (clkPE),
            .d  (w_master_q[i]),
            .q  (outp[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_flip_flop.sv
`default_nettype none
// ============================================================================
// Module   : tb_flip_flop
// Brief    : Directed bench for flip_flop with a 1-bit and an 8-bit instance.
// Revision : 1.0
// ============================================================================
module tb_flip_flop;

    logic       clk;
    logic       rstN;
    logic [0:0] inp1;
    logic [0:0] outp1;
    logic [7:0] inp8;
    logic [7:0] outp8;

    int vectors;
    int miscompares;

    flip_flop #(.WIDTH(1)) u_dut1 (
        .clkPE (clk),
        .rstN  (rstN),
        .inp   (inp1),
        .outp  (outp1)
    );

    flip_flop #(.WIDTH(8)) u_dut8 (
        .clkPE (clk),
        .rstN  (rstN),
        .inp   (inp8),
        .outp  (outp8)
    );

    // Rising edges at t=9, 19, 29, ...; falling edges at t=14, 24, ...
    initial begin
        clk = 1'b0;
        #9;
        forever begin
            clk = 1'b1;
            #5;
            clk = 1'b0;
            #5;
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic test_basic();
        inp1 = 1'b0; inp8 = 8'h00; rstN = 1'b1;
        #5 inp1 = 1'b1;
        #5;  // t=10
        vectors++;
        if (outp1 !== 1'b1) begin miscompares++; $display("FAIL basic_t10: got %b, required 1", outp1); end
        #5 inp1 = 1'b0;
        #5;  // t=20
        vectors++;
        if (outp1 !== 1'b0) begin miscompares++; $display("FAIL basic_t20: got %b, required 0", outp1); end
        #5 inp1 = 1'b1;
        #5;  // t=30
        vectors++;
        if (outp1 !== 1'b1) begin miscompares++; $display("FAIL basic_t30: got %b, required 1", outp1); end
        #5 inp1 = 1'b0;
        #5;  // t=40
        vectors++;
        if (outp1 !== 1'b0) begin miscompares++; $display("FAIL basic_t40: got %b, required 0", outp1); end
        #5;  // t=45
        vectors++;
        if (outp1 !== 1'b0) begin miscompares++; $display("FAIL basic_t45: got %b, required 0", outp1); end
        #5;  // t=50
        vectors++;
        if (outp1 !== 1'b0) begin miscompares++; $display("FAIL basic_t50: got %b, required 0", outp1); end
    endtask

    task automatic test_no_transparency();
        // t=50, clock high until 54
        inp1 = 1'b1;
        #1 inp1 = 1'b0;
        #1 inp1 = 1'b1;
        #1;  // t=53
        vectors++;
        if (outp1 !== 1'b0) begin miscompares++; $display("FAIL notrans_high: got %b, required 0", outp1); end
        #2 inp1 = 1'b0;  // t=55, clock low
        #1 inp1 = 1'b1;
        #1 inp1 = 1'b0;
        #1 inp1 = 1'b1;  // t=58
        vectors++;
        if (outp1 !== 1'b0) begin miscompares++; $display("FAIL notrans_low: got %b, required 0", outp1); end
        #2;  // t=60
        vectors++;
        if (outp1 !== 1'b1) begin miscompares++; $display("FAIL notrans_edge: got %b, required 1", outp1); end
        #5;  // t=65
        vectors++;
        if (outp1 !== 1'b1) begin miscompares++; $display("FAIL hold_mid: got %b, required 1", outp1); end
        #5;  // t=70, edge at 69 with inp equal to outp
        vectors++;
        if (outp1 !== 1'b1) begin miscompares++; $display("FAIL hold_edge: got %b, required 1", outp1); end
    endtask

    task automatic test_sync_reset();
        inp8 = 8'hFF;
        #2 rstN = 1'b0;  // t=72
        #4;  // t=76
        vectors++;
        if (outp1 !== 1'b1) begin miscompares++; $display("FAIL reset_before_edge: got %b, required 1", outp1); end
        #4;  // t=80
        vectors++;
        if (outp1 !== 1'b0) begin miscompares++; $display("FAIL reset_edge: got %b, required 0", outp1); end
        vectors++;
        if (outp8 !== 8'h00) begin miscompares++; $display("FAIL reset_edge_w8: got %h, required 00", outp8); end
        for (int k = 0; k < 3; k++) begin
            #10;  // t=90, 100, 110
            vectors++;
            if (outp1 !== 1'b0) begin miscompares++; $display("FAIL reset_hold_%0d: got %b, required 0", k, outp1); end
        end
    endtask

    task automatic test_reset_release();
        #3 rstN = 1'b1;  // t=113
        #5;  // t=118
        vectors++;
        if (outp1 !== 1'b0) begin miscompares++; $display("FAIL release_before_edge: got %b, required 0", outp1); end
        #2;  // t=120
        vectors++;
        if (outp1 !== 1'b1) begin miscompares++; $display("FAIL release_edge: got %b, required 1", outp1); end
        vectors++;
        if (outp8 !== 8'hFF) begin miscompares++; $display("FAIL release_edge_w8: got %h, required ff", outp8); end
    endtask

    task automatic test_wide();
        #2 inp8 = 8'hA5;
        #8;  // t=130
        vectors++;
        if (outp8 !== 8'hA5) begin miscompares++; $display("FAIL wide_a5: got %h, required a5", outp8); end
        #2 inp8 = 8'h3C;
        #8;  // t=140
        vectors++;
        if (outp8 !== 8'h3C) begin miscompares++; $display("FAIL wide_3c: got %h, required 3c", outp8); end
        #2 begin rstN = 1'b0; inp8 = 8'hFF; end
        #8;  // t=150
        vectors++;
        if (outp8 !== 8'h00) begin miscompares++; $display("FAIL wide_reset: got %h, required 00", outp8); end
        #2 begin rstN = 1'b1; inp8 = 8'h81; inp1 = 1'b0; end
        #8;  // t=160
        vectors++;
        if (outp8 !== 8'h81) begin miscompares++; $display("FAIL wide_81: got %h, required 81", outp8); end
        vectors++;
        if (outp1 !== 1'b0) begin miscompares++; $display("FAIL narrow_after_wide: got %b, required 0", outp1); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_basic();
        test_no_transparency();
        test_sync_reset();
        test_reset_release();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
